// File: rtl/dwt_lift_stream_pkg.sv
// Shared types and width helpers for the streaming lifting DWT.
package dwt_lift_stream_pkg;

  typedef enum logic [1:0] {
    FIRST_E = 2'd0,
    FIRST_O = 2'd1,
    ST_E    = 2'd2,
    ST_O    = 2'd3
  } state_e;

  typedef enum logic {
    MODE_HAAR = 1'b0,
    MODE_53   = 1'b1
  } mode_e;

  // Output coefficient width for a given input sample width.
  function automatic int unsigned out_w(input int unsigned dw);
    return dw + 1;
  endfunction

  // Internal lifting arithmetic width for a given input sample width.
  function automatic int unsigned int_w(input int unsigned dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/dwt_lift_stream_if.sv
// Sample-in / coefficient-pair-out stream bundle for dwt_lift_stream.
interface dwt_lift_stream_if #(
  parameter int unsigned DATA_W = 16
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic                     s_last;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W:0]   m_an;
  logic signed [DATA_W:0]   m_dn;
  logic                     m_last;

  // DUT side: consumes samples, produces pairs.
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_an, m_dn, m_last
  );

  // Environment side: produces samples, consumes pairs.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_an, m_dn, m_last
  );
endinterface

// File: rtl/dwt_lift_stream_core.sv
// Combinational predict/update datapath for Haar and LeGall 5/3 lifting.
module dwt_lift_core
  import dwt_lift_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic signed [DATA_W-1:0]         e,
  input  logic signed [DATA_W-1:0]         o,
  input  logic signed [DATA_W-1:0]         e_next,
  input  logic signed [int_w(DATA_W)-1:0]  dprev,
  input  logic                             first,
  input  logic                             mode53,
  output logic signed [int_w(DATA_W)-1:0]  a_c,
  output logic signed [int_w(DATA_W)-1:0]  d_c
);
  localparam int unsigned IW = int_w(DATA_W);
  localparam logic signed [IW-1:0] TWO = IW'(2);

  logic signed [IW-1:0] ee, oo, en;
  logic signed [IW-1:0] d_haar, a_haar, d_53, a_53, dp;

  // Predict then update; the first pair of a frame mirrors d[n] into d[n-1].
  always_comb begin
    ee     = IW'(e);
    oo     = IW'(o);
    en     = IW'(e_next);
    d_haar = oo - ee;
    a_haar = ee + (d_haar >>> 1);
    d_53   = oo - ((ee + en) >>> 1);
    dp     = first ? d_53 : dprev;
    a_53   = ee + ((dp + d_53 + TWO) >>> 2);
    a_c    = mode53 ? a_53 : a_haar;
    d_c    = mode53 ? d_53 : d_haar;
  end

endmodule

// File: rtl/dwt_lift_stream.sv
// Streaming single-level integer lifting DWT (Haar or LeGall 5/3 per frame).
module dwt_lift_stream
  import dwt_lift_stream_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter bit          SUPPORT_53 = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_mode,
  dwt_lift_stream_if.slave    bus,
  output logic                err_odd
);
  localparam int unsigned IW  = int_w(DATA_W);
  localparam int unsigned DW1 = out_w(DATA_W);

  state_e                   state_q, state_d;
  mode_e                    mode_q, mode_d;
  logic signed [DATA_W-1:0] e_q, e_d, o_q, o_d;
  logic signed [IW-1:0]     dprev_q, dprev_d;
  logic                     first_q, first_d;
  logic                     mv_d, last_d, err_d;
  logic signed [DW1-1:0]    an_d, dn_d;

  logic                     acc;
  logic signed [DATA_W-1:0] o_sel, en_sel;
  logic signed [IW-1:0]     a_w, d_w;
  mode_e                    mode_in;

  // Upstream may only push when the output slot is free or draining this cycle.
  assign bus.s_ready = !bus.m_valid | bus.m_ready;
  assign acc         = bus.s_valid & bus.s_ready;
  assign mode_in     = SUPPORT_53 ? mode_e'(cfg_mode) : MODE_HAAR;

  // In ST_E the incoming sample is x[2n+2]; elsewhere it is the odd sample
  // and the right neighbour defaults to the held even (symmetric extension).
  assign o_sel  = (state_q == ST_E) ? o_q : bus.s_data;
  assign en_sel = (state_q == ST_E) ? bus.s_data : e_q;

  dwt_lift_core #(.DATA_W(DATA_W)) u_core (
    .e      (e_q),
    .o      (o_sel),
    .e_next (en_sel),
    .dprev  (dprev_q),
    .first  (first_q),
    .mode53 (mode_q == MODE_53),
    .a_c    (a_w),
    .d_c    (d_w)
  );

  // Next-state, holding-register and output-register updates.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    e_d     = e_q;
    o_d     = o_q;
    dprev_d = dprev_q;
    first_d = first_q;
    mv_d    = bus.m_valid & !bus.m_ready;
    an_d    = bus.m_an;
    dn_d    = bus.m_dn;
    last_d  = bus.m_last;
    err_d   = 1'b0;
    if (acc) begin
      unique case (state_q)
        FIRST_E: begin
          e_d     = bus.s_data;
          mode_d  = mode_in;
          first_d = 1'b1;
          if (bus.s_last) err_d = 1'b1;
          else            state_d = FIRST_O;
        end
        FIRST_O: begin
          o_d = bus.s_data;
          if (mode_q == MODE_HAAR || bus.s_last) begin
            mv_d    = 1'b1;
            an_d    = DW1'(a_w);
            dn_d    = DW1'(d_w);
            last_d  = bus.s_last;
            state_d = FIRST_E;
          end else begin
            state_d = ST_E;
          end
        end
        ST_E: begin
          mv_d    = 1'b1;
          an_d    = DW1'(a_w);
          dn_d    = DW1'(d_w);
          last_d  = 1'b0;
          e_d     = bus.s_data;
          dprev_d = d_w;
          first_d = 1'b0;
          if (bus.s_last) begin
            err_d   = 1'b1;
            state_d = FIRST_E;
          end else begin
            state_d = ST_O;
          end
        end
        ST_O: begin
          o_d = bus.s_data;
          if (bus.s_last) begin
            mv_d    = 1'b1;
            an_d    = DW1'(a_w);
            dn_d    = DW1'(d_w);
            last_d  = 1'b1;
            state_d = FIRST_E;
          end else begin
            state_d = ST_E;
          end
        end
        default: state_d = FIRST_E;
      endcase
    end
  end

  // State, holding and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FIRST_E;
      mode_q      <= MODE_HAAR;
      e_q         <= '0;
      o_q         <= '0;
      dprev_q     <= '0;
      first_q     <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_an    <= '0;
      bus.m_dn    <= '0;
      bus.m_last  <= 1'b0;
      err_odd     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      e_q         <= e_d;
      o_q         <= o_d;
      dprev_q     <= dprev_d;
      first_q     <= first_d;
      bus.m_valid <= mv_d;
      bus.m_an    <= an_d;
      bus.m_dn    <= dn_d;
      bus.m_last  <= last_d;
      err_odd     <= err_d;
    end
  end

endmodule

// File: tb/tb_dwt_lift_stream.sv
// Self-checking bench for dwt_lift_stream: frame-level model plus per-cycle compare.
module tb_dwt_lift_stream;

  localparam int DW = 16;

  typedef struct {
    int an;
    int dn;
    bit last;
  } exp_t;

  logic clk;
  logic rst_n;
  logic cfg_mode;
  logic err_odd;

  dwt_lift_stream_if #(.DATA_W(DW)) bus ();

  dwt_lift_stream #(.DATA_W(DW), .SUPPORT_53(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_mode (cfg_mode),
    .bus      (bus),
    .err_odd  (err_odd)
  );

  int   checks   = 0;
  int   errors   = 0;
  int   exp_err  = 0;
  int   err_seen = 0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Truncate to the DATA_W+1 output width, keeping the sign.
  function automatic int trunc_out(input int v);
    logic signed [DW:0] t;
    t = (DW+1)'(v);
    return int'(t);
  endfunction

  // Frame-level reference: whole frame in, list of expected pairs out.
  task automatic model(input int xs[8], input int len, input bit m53);
    int np;
    int dprev;
    int e, o, en, d, a, dp;
    exp_t it;
    np = len / 2;
    dprev = 0;
    for (int n = 0; n < np; n++) begin
      e  = xs[2*n];
      o  = xs[2*n+1];
      en = (2*n + 2 < len) ? xs[2*n+2] : e;
      if (!m53) begin
        d = o - e;
        a = e + (d >>> 1);
      end else begin
        d  = o - ((e + en) >>> 1);
        dp = (n == 0) ? d : dprev;
        a  = e + ((dp + d + 2) >>> 2);
        dprev = d;
      end
      it.an   = trunc_out(a);
      it.dn   = trunc_out(d);
      it.last = (n == np - 1) && (len % 2 == 0);
      exp_q.push_back(it);
    end
    if (len % 2 != 0) exp_err++;
  endtask

  task automatic pin(input string nm, input int idx, input int an, input int dn, input bit last);
    chk({nm, "_an"}, exp_q[idx].an, an);
    chk({nm, "_dn"}, exp_q[idx].dn, dn);
    chk({nm, "_last"}, int'(exp_q[idx].last), int'(last));
  endtask

  // Per-cycle compare: every valid output must match the queue head and hold while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pair", 1, 0);
        end else begin
          chk("m_an", int'(bus.m_an), exp_q[0].an);
          chk("m_dn", int'(bus.m_dn), exp_q[0].dn);
          chk("m_last", int'(bus.m_last), int'(exp_q[0].last));
          if (bus.m_ready) void'(exp_q.pop_front());
        end
        if (!bus.m_ready) chk("s_ready_stall", int'(bus.s_ready), 0);
      end
      if (err_odd) err_seen++;
    end
  end

  // Present one sample and wait (bounded) for it to be accepted.
  task automatic send(input int v, input bit last);
    bit done;
    bit rdy;
    int n;
    done = 1'b0;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = DW'(v);
    bus.s_last  = last;
    while (!done && n < 50) begin
      @(negedge clk);
      rdy = bus.s_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
      n++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk({nm, "_pending"}, exp_q.size(), 0);
    chk({nm, "_err_odd"}, err_seen, exp_err);
  endtask

  // Drive a frame; optionally flip cfg_mode after the first sample and stall
  // the output for 5 cycles in front of sample stall_at.
  task automatic run_frame(input int xs[8], input int len, input bit m53,
                           input bit toggle, input int stall_at);
    cfg_mode = m53;
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) begin
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = DW'(xs[i]);
        bus.s_last  = (i == len - 1);
        repeat (5) @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
      end
      send(xs[i], i == len - 1);
      if (i == 0 && toggle) cfg_mode = ~m53;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_mode    = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_an", int'(bus.m_an), 0);
    chk("rst_m_dn", int'(bus.m_dn), 0);
    chk("rst_m_last", int'(bus.m_last), 0);
    chk("rst_err_odd", int'(err_odd), 0);
    chk("rst_s_ready", int'(bus.s_ready), 1);
    @(posedge clk);
    #1;

    // Haar even frame.
    model('{10, 14, -3, 5, 0, 0, 0, 0}, 4, 1'b0);
    pin("t1_p0", 0, 12, 4, 1'b0);
    pin("t1_p1", 1, 1, 8, 1'b1);
    run_frame('{10, 14, -3, 5, 0, 0, 0, 0}, 4, 1'b0, 1'b0, -1);
    drain("t1");

    // 5/3 even frame with both boundary rules.
    model('{10, 14, -3, 5, 0, 0, 0, 0}, 4, 1'b1);
    pin("t2_p0", 0, 16, 11, 1'b0);
    pin("t2_p1", 1, 2, 8, 1'b1);
    run_frame('{10, 14, -3, 5, 0, 0, 0, 0}, 4, 1'b1, 1'b0, -1);
    drain("t2");

    // 5/3 two-sample frame.
    model('{7, 3, 0, 0, 0, 0, 0, 0}, 2, 1'b1);
    pin("t3_p0", 0, 5, -4, 1'b1);
    run_frame('{7, 3, 0, 0, 0, 0, 0, 0}, 2, 1'b1, 1'b0, -1);
    drain("t3");

    // Backpressure with mid-frame cfg_mode flip; same pairs as the plain 5/3 frame.
    model('{10, 14, -3, 5, 0, 0, 0, 0}, 4, 1'b1);
    run_frame('{10, 14, -3, 5, 0, 0, 0, 0}, 4, 1'b1, 1'b1, 3);
    drain("t4");

    // Odd-length Haar frame, then a clean frame behind it.
    model('{1, 2, 3, 0, 0, 0, 0, 0}, 3, 1'b0);
    pin("t5_p0", 0, 1, 1, 1'b0);
    run_frame('{1, 2, 3, 0, 0, 0, 0, 0}, 3, 1'b0, 1'b0, -1);
    model('{10, 14, -3, 5, 0, 0, 0, 0}, 4, 1'b0);
    run_frame('{10, 14, -3, 5, 0, 0, 0, 0}, 4, 1'b0, 1'b0, -1);
    drain("t5");

    // Longer 5/3 frames, even and odd length, back to back.
    model('{8, 2, 6, 4, 10, 12, 0, 0}, 6, 1'b1);
    run_frame('{8, 2, 6, 4, 10, 12, 0, 0}, 6, 1'b1, 1'b0, -1);
    model('{-5, 9, 1, -7, 3, 0, 0, 0}, 5, 1'b1);
    run_frame('{-5, 9, 1, -7, 3, 0, 0, 0}, 5, 1'b1, 1'b0, -1);
    drain("t5b");

    // Async reset with a pending pair mid 5/3 frame.
    cfg_mode = 1'b1;
    model('{10, 14, -3, 5, 0, 0, 0, 0}, 4, 1'b1);
    send(10, 1'b0);
    send(14, 1'b0);
    send(-3, 1'b0);
    bus.m_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_m_valid", int'(bus.m_valid), 0);
    chk("t6_rst_m_an", int'(bus.m_an), 0);
    chk("t6_rst_m_dn", int'(bus.m_dn), 0);
    chk("t6_rst_m_last", int'(bus.m_last), 0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    model('{4, 4, 4, 4, 0, 0, 0, 0}, 4, 1'b1);
    pin("t6_p0", 0, 4, 0, 1'b0);
    pin("t6_p1", 1, 4, 0, 1'b1);
    run_frame('{4, 4, 4, 4, 0, 0, 0, 0}, 4, 1'b1, 1'b1, -1);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
